seq_mult_nxm: RTL

Iterative, parametrised n×m multiplier that retires R multiplier bits per clock behind valid/ready handshakes. It supports unsigned and two's-complement signed operands selected per operation. It is the area-lean, registered successor to the combinational array multiplier, for datapaths that can trade latency for gates. Each partial-product accumulation step is built on the existing `rca_n` ripple-carry adder.

---
 rtl/seq_mult_nxm_pkg.sv | 20 ++
 rtl/seq_mult_nxm_rca_n.sv | 23 ++
 rtl/seq_mult_nxm.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/seq_mult_nxm_pkg.sv
// Shared definitions for the iterative n x m multiplier: state encoding and
// step-count helpers derived from the multiplier width and radix.
package seq_mult_nxm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of accumulation steps: ceil(m / r).
  function automatic int num_steps(input int m, input int r);
    return (m + r - 1) / r;
  endfunction

  function automatic int cnt_width(input int s);
    return $clog2(s + 1);
  endfunction

endpackage

// File: rtl/seq_mult_nxm_rca_n.sv
// Plain ripple-carry adder used as the partial-product accumulation step.
module rca_n #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < W; gi++) begin : g_fa
    assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = carry[W];

endmodule

// File: rtl/seq_mult_nxm.sv
// Iterative n x m multiplier retiring R multiplier bits per cycle, signed or
// unsigned per operation, with valid/ready handshakes on both sides.
module seq_mult_nxm
  import seq_mult_nxm_pkg::*;
#(
  parameter int N = 32,
  parameter int M = 32,
  parameter int R = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [M-1:0]   b,
  input  logic           signed_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N+M-1:0] p,
  output logic           busy
);

  localparam int S  = num_steps(M, R);
  localparam int CW = cnt_width(S);
  localparam int BW = S * R;
  localparam int AW = N + BW;
  localparam int PW = N + M;

  state_t          state_reg;
  logic [N-1:0]    mag_a_reg;
  logic [BW-1:0]   mag_b_reg;
  logic            neg_reg;
  logic [AW-1:0]   acc_reg;
  logic [CW-1:0]   step_reg;
  logic [PW-1:0]   p_reg;
  logic            in_ready_reg;
  logic            out_valid_reg;
  logic            busy_reg;

  logic [N-1:0]    a_mag;
  logic [M-1:0]    b_mag;
  logic [N+R-1:0]  pp_term [R];
  logic [N+R-1:0]  pp;
  logic [N+R-1:0]  step_sum;
  logic            carry_unused;
  logic [AW-1:0]   acc_next;
  logic [PW-1:0]   prod_mag;

  // Most-negative operands negate to 2^(W-1), which is still representable unsigned.
  assign a_mag = (signed_mode && a[N-1]) ? -a : a;
  assign b_mag = (signed_mode && b[M-1]) ? -b : b;

  for (genvar gi = 0; gi < R; gi++) begin : g_pp
    assign pp_term[gi] = mag_b_reg[gi] ? ({{R{1'b0}}, mag_a_reg} << gi) : '0;
  end

  always_comb begin
    pp = '0;
    for (int i = 0; i < R; i++) begin
      pp = pp + pp_term[i];
    end
  end

  // Top N accumulator bits plus the new partial product never exceed N+R bits.
  rca_n #(.W(N + R)) u_step_add (
    .a   ({{R{1'b0}}, acc_reg[AW-1 -: N]}),
    .b   (pp),
    .cin (1'b0),
    .sum (step_sum),
    .cout(carry_unused)
  );

  // Right-shifting accumulator: retired low bits slide down by R each step.
  if (S == 1) begin : g_acc_single
    assign acc_next = step_sum;
  end else begin : g_acc_multi
    assign acc_next = {step_sum, acc_reg[BW-1:R]};
  end

  assign prod_mag = acc_next[PW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      p_reg         <= '0;
      acc_reg       <= '0;
      step_reg      <= '0;
      mag_a_reg     <= '0;
      mag_b_reg     <= '0;
      neg_reg       <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            mag_a_reg    <= a_mag;
            mag_b_reg    <= BW'(b_mag);
            neg_reg      <= signed_mode & (a[N-1] ^ b[M-1]);
            acc_reg      <= '0;
            step_reg     <= '0;
            state_reg    <= ST_BUSY;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        ST_BUSY: begin
          acc_reg   <= acc_next;
          mag_b_reg <= mag_b_reg >> R;
          step_reg  <= step_reg + CW'(1);
          if (step_reg == CW'(S - 1)) begin
            p_reg         <= neg_reg ? -prod_mag : prod_mag;
            state_reg     <= ST_DONE;
            out_valid_reg <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign p         = p_reg;

endmodule
